contador_hexadecimal_pulsador: RTL and testbench

Debounced push-button hex counter that generates the four 4-bit nibbles driving four binary-to-hexadecimal seven-segment decoders on the DE-10 Lite. Each validated press of a raw, active-low KEY increments or decrements a 16-bit count by one. The count wraps modulo 2^16 and can be cleared from a slide switch. `Digito0`..`Digito3` connect directly to the `Binario` inputs of the decoder instances.

---
 rtl/contador_hexadecimal_pulsador.sv | 133 +++++++++++++
 tb/tb_contador_hexadecimal_pulsador.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/contador_hexadecimal_pulsador.sv
// Debounced push-button 16-bit hex counter feeding four seven-segment decoders.
// One count per validated press of an active-low key; wraps mod 2^16, clearable.
module contador_hexadecimal_pulsador #(
    parameter int unsigned CICLOS_ANTIRREBOTE = 500000
) (
    input  logic       Reloj,
    input  logic       Reset_n,
    input  logic       Pulsador,
    input  logic       Direccion,
    input  logic       Limpiar,
    output logic [3:0] Digito0,
    output logic [3:0] Digito1,
    output logic [3:0] Digito2,
    output logic [3:0] Digito3,
    output logic       Pulso
);

    localparam int unsigned TW = $clog2(CICLOS_ANTIRREBOTE + 1);
    localparam int unsigned CW = 16;
    localparam logic [TW-1:0] T_FIN = TW'(CICLOS_ANTIRREBOTE);
    localparam logic [TW-1:0] T_UNO = TW'(1);

    typedef enum logic [1:0] {
        REPOSO,
        VALIDA_PRESION,
        PRESIONADO,
        VALIDA_LIBERACION
    } estado_t;

    logic pulsador_meta, pulsador_s;
    logic direccion_meta, direccion_s;
    logic limpiar_meta, limpiar_s;

    estado_t       estado, estado_sig;
    logic [TW-1:0] timer, timer_sig;
    logic          evento_c;
    logic [CW-1:0] cuenta;

    // Two-flop synchronisers; the key resets to released so no false press follows reset.
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            pulsador_meta  <= 1'b1;
            pulsador_s     <= 1'b1;
            direccion_meta <= 1'b0;
            direccion_s    <= 1'b0;
            limpiar_meta   <= 1'b0;
            limpiar_s      <= 1'b0;
        end else begin
            pulsador_meta  <= Pulsador;
            pulsador_s     <= pulsador_meta;
            direccion_meta <= Direccion;
            direccion_s    <= direccion_meta;
            limpiar_meta   <= Limpiar;
            limpiar_s      <= limpiar_meta;
        end
    end

    // Debounce state register.
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado <= REPOSO;
            timer  <= '0;
        end else begin
            estado <= estado_sig;
            timer  <= timer_sig;
        end
    end

    // Debounce next-state: any disagreeing sample aborts a validation window.
    always_comb begin
        estado_sig = estado;
        timer_sig  = timer;
        evento_c   = 1'b0;
        case (estado)
            REPOSO: begin
                if (!pulsador_s) begin
                    estado_sig = VALIDA_PRESION;
                    timer_sig  = T_UNO;
                end
            end
            VALIDA_PRESION: begin
                if (pulsador_s) begin
                    estado_sig = REPOSO;
                end else if (timer == T_FIN) begin
                    estado_sig = PRESIONADO;
                    evento_c   = 1'b1;
                end else begin
                    timer_sig = timer + T_UNO;
                end
            end
            PRESIONADO: begin
                if (pulsador_s) begin
                    estado_sig = VALIDA_LIBERACION;
                    timer_sig  = T_UNO;
                end
            end
            VALIDA_LIBERACION: begin
                if (!pulsador_s) begin
                    estado_sig = PRESIONADO;
                end else if (timer == T_FIN) begin
                    estado_sig = REPOSO;
                end else begin
                    timer_sig = timer + T_UNO;
                end
            end
            default: begin
                estado_sig = REPOSO;
                timer_sig  = '0;
            end
        endcase
    end

    // Counter and strobe; clear wins over a coincident count event.
    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            cuenta <= '0;
            Pulso  <= 1'b0;
        end else begin
            Pulso <= evento_c && !limpiar_s;
            if (limpiar_s) begin
                cuenta <= '0;
            end else if (evento_c) begin
                cuenta <= direccion_s ? cuenta + CW'(1) : cuenta - CW'(1);
            end
        end
    end

    assign Digito0 = cuenta[3:0];
    assign Digito1 = cuenta[7:4];
    assign Digito2 = cuenta[11:8];
    assign Digito3 = cuenta[15:12];

endmodule

// File: tb/tb_contador_hexadecimal_pulsador.sv
// Bench for contador_hexadecimal_pulsador: directed scenarios plus random key
// activity, checked every cycle against a level-debounce reference model.
module tb_contador_hexadecimal_pulsador;

    localparam int unsigned N = 4;

    logic       Reloj;
    logic       Reset_n;
    logic       Pulsador;
    logic       Direccion;
    logic       Limpiar;
    logic [3:0] Digito0, Digito1, Digito2, Digito3;
    logic       Pulso;

    int tests = 0;
    int fails = 0;

    // Reference model: inputs seen by the logic lag the pins by two edges; the
    // debounced key flips after N+1 consecutive samples disagreeing with it.
    logic        m_p1, m_p2, m_d1, m_d2, m_l1, m_l2;
    logic        m_pressed;
    int          m_run;
    logic [15:0] m_cnt;
    logic        m_pulso;

    contador_hexadecimal_pulsador #(.CICLOS_ANTIRREBOTE(N)) dut (
        .Reloj     (Reloj),
        .Reset_n   (Reset_n),
        .Pulsador  (Pulsador),
        .Direccion (Direccion),
        .Limpiar   (Limpiar),
        .Digito0   (Digito0),
        .Digito1   (Digito1),
        .Digito2   (Digito2),
        .Digito3   (Digito3),
        .Pulso     (Pulso)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    function automatic logic [15:0] digits();
        return {Digito3, Digito2, Digito1, Digito0};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p1 = 1'b1; m_p2 = 1'b1;
        m_d1 = 1'b0; m_d2 = 1'b0;
        m_l1 = 1'b0; m_l2 = 1'b0;
        m_pressed = 1'b0;
        m_run     = 0;
        m_cnt     = 16'h0000;
        m_pulso   = 1'b0;
    endtask

    // One clock edge: advance the model with the pin values, then compare.
    task automatic step();
        logic ps, ds, ls, ev;
        @(posedge Reloj);
        ps = m_p2; m_p2 = m_p1; m_p1 = Pulsador;
        ds = m_d2; m_d2 = m_d1; m_d1 = Direccion;
        ls = m_l2; m_l2 = m_l1; m_l1 = Limpiar;
        ev = 1'b0;
        if (m_pressed ? ps : !ps) begin
            m_run++;
            if (m_run == int'(N) + 1) begin
                m_pressed = !m_pressed;
                m_run     = 0;
                ev        = m_pressed;
            end
        end else begin
            m_run = 0;
        end
        if (ls)      m_cnt = 16'h0000;
        else if (ev) m_cnt = ds ? m_cnt + 16'd1 : m_cnt - 16'd1;
        m_pulso = ev && !ls;
        #1;
        check("count", digits(), m_cnt);
        check("pulso", 16'(Pulso), 16'(m_pulso));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press();
        Pulsador = 1'b0;
        run(10);
        Pulsador = 1'b1;
        run(10);
    endtask

    task automatic hold_reset_and_release();
        @(posedge Reloj);
        @(posedge Reloj);
        #1;
        check("reset_hold_count", digits(), 16'h0000);
        check("reset_hold_pulso", 16'(Pulso), 16'h0000);
        Reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        Pulsador  = 1'b1;
        Direccion = 1'b1;
        Limpiar   = 1'b0;
        Reset_n   = 1'b0;
        model_reset();
        hold_reset_and_release();

        // Clean press, held 20 cycles
        Direccion = 1'b1;
        Pulsador  = 1'b0;
        run(6);
        check("press_before", digits(), 16'h0000);
        step();
        check("press_edge6", digits(), 16'h0001);
        check("press_pulso", 16'(Pulso), 16'h0001);
        step();
        check("press_pulso_off", 16'(Pulso), 16'h0000);
        run(12);
        Pulsador = 1'b1;
        run(12);
        check("press_after_release", digits(), 16'h0001);

        // Bouncing press
        Pulsador = 1'b0; run(3);
        Pulsador = 1'b1; run(1);
        Pulsador = 1'b0; run(2);
        Pulsador = 1'b1; run(1);
        Pulsador = 1'b0; run(6);
        check("bounce_before", digits(), 16'h0001);
        step();
        check("bounce_edge6", digits(), 16'h0002);
        run(8);
        Pulsador = 1'b1;
        run(12);
        check("bounce_single", digits(), 16'h0002);

        // Wrap both ways
        Limpiar = 1'b1; run(3);
        Limpiar = 1'b0; run(3);
        check("clear_to_zero", digits(), 16'h0000);
        Direccion = 1'b0;
        press();
        check("wrap_down", digits(), 16'hFFFF);
        Direccion = 1'b1;
        press();
        check("wrap_up", digits(), 16'h0000);

        // Clear from 0x0003, then clear coinciding with a count event
        press(); press(); press();
        check("count_three", digits(), 16'h0003);
        Limpiar = 1'b1;
        run(2);
        check("clear_edge1", digits(), 16'h0003);
        step();
        check("clear_edge2", digits(), 16'h0000);
        check("clear_pulso", 16'(Pulso), 16'h0000);
        Limpiar = 1'b0;
        run(3);
        press();
        check("pre_coincide", digits(), 16'h0001);
        Pulsador = 1'b0;
        run(4);
        Limpiar = 1'b1;
        step();
        Limpiar = 1'b0;
        step();
        step();
        check("coincide_count", digits(), 16'h0000);
        check("coincide_pulso", 16'(Pulso), 16'h0000);
        run(6);
        Pulsador = 1'b1;
        run(12);
        check("coincide_no_late", digits(), 16'h0000);

        // Asynchronous reset during validation with the key held
        press(); press();
        Pulsador = 1'b0;
        run(4);
        Reset_n = 1'b0;
        #1;
        check("reset_async_count", digits(), 16'h0000);
        check("reset_async_pulso", 16'(Pulso), 16'h0000);
        hold_reset_and_release();
        run(6);
        check("reset_held_before", digits(), 16'h0000);
        step();
        check("reset_held_count", digits(), 16'h0001);
        run(12);
        Pulsador = 1'b1;
        run(12);
        check("reset_held_single", digits(), 16'h0001);

        // Random key, direction and clear activity
        for (int seg = 0; seg < 120; seg++) begin
            Pulsador = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) Direccion = ~Direccion;
            Limpiar = ($urandom_range(0, 30) == 0);
            run(int'($urandom_range(1, 9)));
        end
        Limpiar  = 1'b0;
        Pulsador = 1'b1;
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
